// File: rtl/linreg_accum_initiator.sv
//============================================================================
// Module      : linreg_accum_initiator
// Description : Streams signed (x, y) samples into Sx, Sy, Sxx and Sxy
//               accumulators. At batch end it issues a one-cycle request
//               to an XtX inverse responder and waits, with a cycle bound,
//               for the responder's result.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module linreg_accum_initiator #(
  parameter int DATA_W      = 16,
  parameter int ACC_W       = 32,
  parameter int MAX_SAMPLES = 1024,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_x,
  input  logic [DATA_W-1:0]            in_y,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic                         inv_start,
  output logic [ACC_W-1:0]             inv_x,
  output logic [ACC_W-1:0]             inv_y,
  output logic [$clog2(MAX_SAMPLES):0] n_cnt,
  output logic [ACC_W-1:0]             sum_y,
  output logic [ACC_W-1:0]             sum_xy,
  input  logic                         inv_finished,
  input  logic [ACC_W-1:0]             inv_result,
  output logic [ACC_W-1:0]             result,
  output logic                         done,
  output logic                         err_timeout,
  output logic                         err_ovf,
  output logic                         trunc
);

  localparam int CNT_W  = $clog2(MAX_SAMPLES) + 1;
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  // Accumulators and status
  logic [ACC_W-1:0]  r_sx;
  logic [ACC_W-1:0]  r_sy;
  logic [ACC_W-1:0]  r_sxx;
  logic [ACC_W-1:0]  r_sxy;
  logic [CNT_W-1:0]  r_n;
  logic [ACC_W-1:0]  r_result;
  logic              r_err_timeout;
  logic              r_err_ovf;
  logic              r_trunc;
  logic [WAIT_W-1:0] r_wait_cnt;

  // Sample terms, widened so the products never lose bits before extension
  logic signed [PROD_W-1:0] w_xs;
  logic signed [PROD_W-1:0] w_ys;
  logic signed [PROD_W-1:0] w_xx;
  logic signed [PROD_W-1:0] w_xy;
  logic        [ACC_W-1:0]  w_x_ext;
  logic        [ACC_W-1:0]  w_y_ext;
  logic        [ACC_W-1:0]  w_xx_ext;
  logic        [ACC_W-1:0]  w_xy_ext;

  logic [ACC_W-1:0] w_sx_sum;
  logic [ACC_W-1:0] w_sy_sum;
  logic [ACC_W-1:0] w_sxx_sum;
  logic [ACC_W-1:0] w_sxy_sum;
  logic             w_ovf_any;

  logic             w_can_accept;
  logic             w_accept;
  logic [CNT_W-1:0] w_n_next;
  logic             w_hit_max;
  logic             w_wait_expired;
  logic             w_timeout;

  // Two's-complement overflow: operands share a sign the sum does not
  function automatic logic add_ovf(input logic [ACC_W-1:0] a,
                                   input logic [ACC_W-1:0] b,
                                   input logic [ACC_W-1:0] s);
    return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
  endfunction

  assign w_xs     = PROD_W'($signed(in_x));
  assign w_ys     = PROD_W'($signed(in_y));
  assign w_xx     = w_xs * w_xs;
  assign w_xy     = w_xs * w_ys;
  assign w_x_ext  = ACC_W'($signed(in_x));
  assign w_y_ext  = ACC_W'($signed(in_y));
  assign w_xx_ext = ACC_W'(w_xx);
  assign w_xy_ext = ACC_W'(w_xy);

  assign w_sx_sum  = r_sx  + w_x_ext;
  assign w_sy_sum  = r_sy  + w_y_ext;
  assign w_sxx_sum = r_sxx + w_xx_ext;
  assign w_sxy_sum = r_sxy + w_xy_ext;
  assign w_ovf_any = add_ovf(r_sx,  w_x_ext,  w_sx_sum)  |
                     add_ovf(r_sy,  w_y_ext,  w_sy_sum)  |
                     add_ovf(r_sxx, w_xx_ext, w_sxx_sum) |
                     add_ovf(r_sxy, w_xy_ext, w_sxy_sum);

  assign w_can_accept = (r_state == IDLE) || (r_state == ACCUM);
  assign w_accept     = in_valid && w_can_accept;
  // A sample taken in IDLE always starts a fresh batch at count 1
  assign w_n_next     = (r_state == IDLE) ? CNT_W'(1) : (r_n + 1'b1);
  assign w_hit_max    = (w_n_next == CNT_W'(MAX_SAMPLES));

  // WAIT lasts at most TIMEOUT_CYC cycles; a completion on the last one wins
  assign w_wait_expired = (r_wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));
  assign w_timeout      = (r_state == WAIT) && !inv_finished && w_wait_expired;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state decode and state-derived handshake outputs
  always_comb begin
    w_state_nx = r_state;
    in_ready   = 1'b0;
    inv_start  = 1'b0;
    done       = 1'b0;
    case (r_state)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nx = (in_last || w_hit_max) ? LAUNCH : ACCUM;
        end
      end
      LAUNCH: begin
        inv_start  = 1'b1;
        w_state_nx = WAIT;
      end
      WAIT: begin
        if (inv_finished || w_wait_expired) begin
          w_state_nx = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Accumulators, sample count and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sx          <= '0;
      r_sy          <= '0;
      r_sxx         <= '0;
      r_sxy         <= '0;
      r_n           <= '0;
      r_err_timeout <= 1'b0;
      r_err_ovf     <= 1'b0;
      r_trunc       <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_state == IDLE) begin
          // New batch: previous sums and status are discarded
          r_sx          <= w_x_ext;
          r_sy          <= w_y_ext;
          r_sxx         <= w_xx_ext;
          r_sxy         <= w_xy_ext;
          r_err_timeout <= 1'b0;
          r_err_ovf     <= 1'b0;
          r_trunc       <= w_hit_max && !in_last;
        end else begin
          r_sx  <= w_sx_sum;
          r_sy  <= w_sy_sum;
          r_sxx <= w_sxx_sum;
          r_sxy <= w_sxy_sum;
          if (w_ovf_any) begin
            r_err_ovf <= 1'b1;
          end
          if (w_hit_max && !in_last) begin
            r_trunc <= 1'b1;
          end
        end
        r_n <= w_n_next;
      end
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
    end
  end

  // Wait-cycle counter, held at zero outside WAIT so each entry starts fresh
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (r_state != WAIT) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Responder result capture; completions outside WAIT are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
    end else if ((r_state == WAIT) && inv_finished) begin
      r_result <= inv_result;
    end
  end

  assign inv_x       = r_sxx;
  assign inv_y       = r_sx;
  assign sum_y       = r_sy;
  assign sum_xy      = r_sxy;
  assign n_cnt       = r_n;
  assign result      = r_result;
  assign err_timeout = r_err_timeout;
  assign err_ovf     = r_err_ovf;
  assign trunc       = r_trunc;

endmodule

`default_nettype wire

// File: doc/linreg_accum_initiator.md
LINREG_ACCUM_INITIATOR -- requirements
Module: linreg_accum_initiator

Interface
REQ-001 Parameter DATA_W, default 16: width of signed sample inputs in_x and in_y.
REQ-002 Parameter ACC_W, default 32: width of every accumulator and of the operand and result buses.
REQ-003 Parameter MAX_SAMPLES, default 1024: maximum samples per batch.
REQ-004 Parameter TIMEOUT_CYC, default 4096: maximum cycles to wait for inv_finished.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  sample present on in_x, in_y and in_last.
REQ-008 in_x  input  DATA_W  signed regressor sample.
REQ-009 in_y  input  DATA_W  signed response sample.
REQ-010 in_last  input  1  marks the final sample of a batch.
REQ-011 in_ready  output  1  block accepts a sample this cycle.
REQ-012 inv_start  output  1  one-cycle request to the XtX inverse responder.
REQ-013 inv_x  output  ACC_W  operand Sxx (sum of x*x).
REQ-014 inv_y  output  ACC_W  operand Sx (sum of x).
REQ-015 n_cnt  output  clog2(MAX_SAMPLES)+1  accepted sample count.
REQ-016 sum_y, sum_xy  output  ACC_W each  Sy and Sxy, for downstream beta computation.
REQ-017 inv_finished  input  1  responder completion pulse.
REQ-018 inv_result  input  ACC_W  responder result, valid with inv_finished.
REQ-019 result  output  ACC_W  captured inverse result.
REQ-020 done  output  1  one-cycle batch-complete pulse.
REQ-021 err_timeout, err_ovf, trunc  output  1 each  sticky status flags, cleared on the next batch start.

Function
REQ-022 The state machine SHALL have states IDLE, ACCUM, LAUNCH, WAIT and DONE.
REQ-023 in_ready SHALL be 1 only in IDLE and ACCUM; a sample is accepted on in_valid && in_ready.
REQ-024 In IDLE, an accepted sample SHALL load the accumulators with that sample alone (prior sums discarded), set n_cnt=1, clear the flags and go to ACCUM; if in_last is also set, the next state SHALL be LAUNCH instead.
REQ-025 In ACCUM, each accepted sample SHALL update Sx+=x, Sy+=y, Sxx+=x*x, Sxy+=x*y (sign-extended to ACC_W, modulo 2^ACC_W) and n_cnt+=1, all in the same cycle.
REQ-026 err_ovf SHALL set if any signed accumulate overflows ACC_W; accumulators keep the wrapped value.
REQ-027 Acceptance of in_last SHALL move ACCUM to LAUNCH.
REQ-028 If the accepted sample makes n_cnt reach MAX_SAMPLES without in_last, the block SHALL treat it as last, set trunc and go to LAUNCH.
REQ-029 LAUNCH SHALL last exactly one cycle, with inv_start=1, then go to WAIT.
REQ-030 inv_x, inv_y, sum_y, sum_xy and n_cnt SHALL stay stable from LAUNCH until the cycle after leaving WAIT.
REQ-031 inv_finished SHALL be sampled only in WAIT; pulses in any other state are ignored.
REQ-032 In WAIT, inv_finished=1 SHALL capture inv_result into result and move to DONE.
REQ-033 In WAIT, a wait counter SHALL reset on entry; on reaching TIMEOUT_CYC cycles without inv_finished, err_timeout SHALL set, result SHALL hold its previous value, and the state SHALL move to DONE.
REQ-034 In DONE, done=1 for exactly one cycle, then IDLE.
REQ-035 Sample-to-start latency SHALL be 1 cycle: in_last is accepted at edge k, inv_start is high in cycle k+1; inv_finished at edge m gives done in cycle m+1.
REQ-036 inv_start SHALL never be asserted outside LAUNCH.

Reset
REQ-037 reset SHALL force IDLE asynchronously and clear all accumulators, n_cnt, result and flags to 0, with inv_start=0, done=0 and in_ready=1 after release.
REQ-038 Reset asserted in WAIT SHALL abandon the transaction; a late inv_finished after release SHALL be ignored.

Verification
REQ-039 Samples (1,2),(2,4),(3,6) with last on the 3rd -> inv_x=14, inv_y=6, sum_y=12, sum_xy=28, n_cnt=3, one inv_start pulse.
REQ-040 Responder returns inv_finished with 0x0000ABCD 5 cycles after start -> result=0x0000ABCD, done pulses 1 cycle later, err flags 0.
REQ-041 No inv_finished -> done after TIMEOUT_CYC, err_timeout=1, result unchanged.
REQ-042 MAX_SAMPLES=4, 6 samples without last -> trunc=1, n_cnt=4, in_ready=0 after the 4th sample.
REQ-043 x=y=0x7FFF repeated with ACC_W=32 until Sxx wraps -> err_ovf=1, and the value equals the modulo sum.
REQ-044 Reset pulse in WAIT, then a stray inv_finished -> state IDLE, result=0, done stays 0.
